// File: rtl/vga_capture_pkg.sv
// Shared VGA timing constants (640x480 defaults) and the capture FSM encoding.
package vga_capture_pkg;

    localparam int VGA_WIDTH       = 640;
    localparam int VGA_HEIGHT      = 480;
    localparam int VGA_HSYNC       = 96;
    localparam int VGA_HBP         = 48;
    localparam int VGA_HTOTAL      = 800;
    localparam int VGA_VSYNC       = 2;
    localparam int VGA_VBP         = 33;
    localparam int VGA_VTOTAL      = 525;
    localparam int VGA_H_ACT_START = VGA_HSYNC + VGA_HBP;
    localparam int VGA_V_ACT_START = VGA_VSYNC + VGA_VBP;
    localparam int VGA_FB_DEPTH    = VGA_WIDTH * VGA_HEIGHT;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 19;
    localparam int RGB_W  = 12;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_ALIGN   = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_t;

endpackage

// File: rtl/vga_timing_check.sv
// Sync-edge-cleared saturating counter with an expected-period compare.
module vga_timing_check
    import vga_capture_pkg::*;
#(
    parameter int PERIOD = VGA_HTOTAL
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             step,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             at_period
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    // Saturation keeps a lost sync from wrapping back into the active window.
    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (step && (cnt != CNT_MAX))
            cnt_nxt = cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

    assign at_period = (cnt == LAST);

endmodule

// File: rtl/vga_capture.sv
// Loop-back VGA receiver: rebuilds pixel coordinates from sync edges and
// emits one framebuffer write per visible pixel once the timing has locked.
module vga_capture
    import vga_capture_pkg::*;
#(
    parameter int WIDTH  = VGA_WIDTH,
    parameter int HEIGHT = VGA_HEIGHT,
    parameter int HSYNC  = VGA_HSYNC,
    parameter int HBP    = VGA_HBP,
    parameter int HTOTAL = VGA_HTOTAL,
    parameter int VSYNC  = VGA_VSYNC,
    parameter int VBP    = VGA_VBP,
    parameter int VTOTAL = VGA_VTOTAL
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              pix_en,
    input  logic              hs,
    input  logic              vs,
    input  logic [3:0]        r,
    input  logic [3:0]        g,
    input  logic [3:0]        b,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [RGB_W-1:0]  dout,
    output logic              locked,
    output logic              frame_done,
    output logic              err,
    output cap_state_t        dbg_state
);

    localparam int H_ACT_START = HSYNC + HBP;
    localparam int V_ACT_START = VSYNC + VBP;
    localparam int FB_DEPTH    = WIDTH * HEIGHT;

    localparam logic [CNT_W-1:0]  H_LO      = CNT_W'(H_ACT_START);
    localparam logic [CNT_W-1:0]  H_HI      = CNT_W'(H_ACT_START + WIDTH);
    localparam logic [CNT_W-1:0]  V_LO      = CNT_W'(V_ACT_START);
    localparam logic [CNT_W-1:0]  V_HI      = CNT_W'(V_ACT_START + HEIGHT);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FB_DEPTH - 1);

    cap_state_t        state, state_nxt;
    logic              hs_q, vs_q;
    logic              hs_fall, vs_fall;
    logic [CNT_W-1:0]  hcnt_nxt, vcnt_nxt;
    logic              h_ok, v_ok, h_bad, v_bad;
    logic              visible, wr_fire, err_set;
    logic [ADDR_W-1:0] wr_ptr;

    // Syncs idle high, so a sync that is already low at the first strobe counts as a fall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else if (pix_en) begin
            hs_q <= hs;
            vs_q <= vs;
        end
    end

    assign hs_fall = pix_en & hs_q & ~hs;
    assign vs_fall = pix_en & vs_q & ~vs;

    vga_timing_check #(.PERIOD(HTOTAL)) u_hchk (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (hs_fall | vs_fall),
        .step      (pix_en),
        .cnt_nxt   (hcnt_nxt),
        .at_period (h_ok)
    );

    vga_timing_check #(.PERIOD(VTOTAL)) u_vchk (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (vs_fall),
        .step      (hs_fall),
        .cnt_nxt   (vcnt_nxt),
        .at_period (v_ok)
    );

    // A vs fall owns its edge: the line-length check is skipped when hs falls with it.
    assign h_bad   = hs_fall & ~vs_fall & ~h_ok;
    assign v_bad   = vs_fall & ~v_ok;
    assign visible = (hcnt_nxt >= H_LO) && (hcnt_nxt < H_HI) &&
                     (vcnt_nxt >= V_LO) && (vcnt_nxt < V_HI);
    assign wr_fire = (state == ST_CAPTURE) && pix_en && visible;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= ST_HUNT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        unique case (state)
            ST_HUNT: begin
                if (vs_fall)
                    state_nxt = ST_ALIGN;
            end
            ST_ALIGN: begin
                if (h_bad || v_bad)
                    state_nxt = ST_HUNT;
                else if (vs_fall)
                    state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (h_bad || v_bad) begin
                    state_nxt = ST_HUNT;
                    err_set   = 1'b1;
                end
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    // we is a one-clk valid with no back-pressure; addr/dout are valid while we is high and hold otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we         <= 1'b0;
            addr       <= '0;
            dout       <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            wr_ptr     <= '0;
        end else begin
            we         <= wr_fire;
            frame_done <= wr_fire && (wr_ptr == ADDR_LAST);
            if (err_set)
                err <= 1'b1;
            if (wr_fire) begin
                addr <= wr_ptr;
                dout <= {r, g, b};
            end
            if (vs_fall)
                wr_ptr <= '0;
            else if (wr_fire && (wr_ptr != ADDR_LAST))
                wr_ptr <= wr_ptr + 1'b1;
        end
    end

    assign locked    = (state == ST_CAPTURE);
    assign dbg_state = state;

endmodule
